// File: rtl/fram_word_bridge_pkg.sv
// Shared FRAM constants: FSM state codes, default geometry/timeout and a lane helper.
// Imported by the word bridge and by the SPI master.
package fram_pkg;

    localparam int FRAM_ADDR_BITS = 13;
    localparam int FRAM_TIMEOUT   = 1024;

    typedef logic [2:0]      fsm_state_t;
    typedef logic [3:0][7:0] word_t;

    localparam fsm_state_t ST_IDLE    = 3'd0;
    localparam fsm_state_t ST_SELECT  = 3'd1;
    localparam fsm_state_t ST_REQ     = 3'd2;
    localparam fsm_state_t ST_RELEASE = 3'd3;
    localparam fsm_state_t ST_DONE    = 3'd4;

    // Marks every byte lane from 'first' upward as unread (8'hFF).
    function automatic word_t pad_unread(input word_t w, input logic [2:0] first);
        word_t r;
        r = w;
        for (int l = 0; l < 4; l++) begin
            if (l >= int'(first)) r[l] = 8'hFF;
        end
        return r;
    endfunction

endpackage

// File: rtl/fram_word_bridge_if.sv
// CPU word port plus downstream FRAM byte port of the word bridge.
// slave = bridge view, master = CPU/SPI-master side view.
interface fram_word_bridge_if
    import fram_pkg::*;
#(
    parameter int ADDR_BITS = FRAM_ADDR_BITS
);
    logic                 mem_valid;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_wstrb;
    logic                 mem_ready;
    logic [31:0]          mem_rdata;
    logic                 err;
    logic [ADDR_BITS-1:0] f_addr;
    logic [7:0]           f_wdata;
    logic                 f_write;
    logic                 f_valid;
    logic                 f_ready;
    logic [7:0]           f_rdata;

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb, f_ready, f_rdata,
        output mem_ready, mem_rdata, err, f_addr, f_wdata, f_write, f_valid
    );

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb, f_ready, f_rdata,
        input  mem_ready, mem_rdata, err, f_addr, f_wdata, f_write, f_valid
    );
endinterface

// File: rtl/fram_word_bridge.sv
// Splits a 32-bit CPU access into up to four FRAM byte handshakes; latency 2 + per lane (1 + req + release) cycles.
// mem_valid must be held until the one-cycle mem_ready; each downstream phase is bounded by TIMEOUT (abort sets err).
module fram_word_bridge
    import fram_pkg::*;
#(
    parameter int ADDR_BITS = FRAM_ADDR_BITS,
    parameter int TIMEOUT   = FRAM_TIMEOUT
) (
    input logic               clk,
    input logic               resetn,
    fram_word_bridge_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    fsm_state_t           r_state;
    logic [ADDR_BITS-3:0] r_word;
    word_t                r_wdata;
    logic [3:0]           r_wstrb;
    logic [2:0]           r_lane;
    logic [TW-1:0]        r_tmo;
    logic                 r_abort;
    word_t                r_rdata;
    logic [ADDR_BITS-1:0] r_f_addr;
    logic [7:0]           r_f_wdata;
    logic                 r_f_write;
    logic                 r_f_valid;

    logic w_is_read;
    logic w_lane_sel;
    logic w_tmo_hit;
    logic w_unused;

    assign w_is_read  = (r_wstrb == 4'b0000);
    assign w_lane_sel = w_is_read || r_wstrb[r_lane[1:0]];
    assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
    // Address bits outside the word index are deliberately dropped (wrap modulo 2^ADDR_BITS).
    assign w_unused   = ^{bus.mem_addr[31:ADDR_BITS], bus.mem_addr[1:0]};

    assign bus.mem_ready = (r_state == ST_DONE);
    assign bus.err       = (r_state == ST_DONE) && r_abort;
    assign bus.mem_rdata = r_rdata;
    assign bus.f_addr    = r_f_addr;
    assign bus.f_wdata   = r_f_wdata;
    assign bus.f_write   = r_f_write;
    assign bus.f_valid   = r_f_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_word    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_lane    <= '0;
            r_tmo     <= '0;
            r_abort   <= 1'b0;
            r_rdata   <= '0;
            r_f_addr  <= '0;
            r_f_wdata <= '0;
            r_f_write <= 1'b0;
            r_f_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A lingering f_ready from the previous access blocks the start.
                    if (bus.mem_valid && !bus.f_ready) begin
                        r_word  <= bus.mem_addr[ADDR_BITS-1:2];
                        r_wdata <= bus.mem_wdata;
                        r_wstrb <= bus.mem_wstrb;
                        r_lane  <= '0;
                        r_abort <= 1'b0;
                        r_state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (r_lane[2]) begin
                        r_state <= ST_DONE;
                    end else if (w_lane_sel) begin
                        r_f_addr  <= {r_word, r_lane[1:0]};
                        r_f_wdata <= r_wdata[r_lane[1:0]];
                        r_f_write <= !w_is_read;
                        r_f_valid <= 1'b1;
                        r_tmo     <= '0;
                        r_state   <= ST_REQ;
                    end else begin
                        r_lane <= r_lane + 3'd1;
                    end
                end
                ST_REQ: begin
                    if (bus.f_ready) begin
                        if (w_is_read) r_rdata[r_lane[1:0]] <= bus.f_rdata;
                        r_f_valid <= 1'b0;
                        r_tmo     <= '0;
                        r_state   <= ST_RELEASE;
                    end else if (w_tmo_hit) begin
                        if (w_is_read) r_rdata <= pad_unread(r_rdata, r_lane);
                        r_abort   <= 1'b1;
                        r_f_valid <= 1'b0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!bus.f_ready) begin
                        r_lane  <= r_lane + 3'd1;
                        r_state <= ST_SELECT;
                    end else if (w_tmo_hit) begin
                        // Current lane was already captured; only later lanes are unread.
                        if (w_is_read) r_rdata <= pad_unread(r_rdata, r_lane + 3'd1);
                        r_abort <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fram_word_bridge.md
FRAM_WORD_BRIDGE -- requirements
Module: fram_word_bridge

Interface
REQ-001 Parameter ADDR_BITS, default 13, SHALL set the FRAM byte-address width.
REQ-002 Parameter TIMEOUT, default 1024, SHALL set the maximum clk cycles to wait on any single downstream handshake phase.
REQ-003 clk  input  1  SHALL be the clock; all logic is rising-edge.
REQ-004 resetn  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 mem_valid  input  1  SHALL be the CPU request, held high until mem_ready.
REQ-006 mem_addr  input  32  SHALL be the CPU byte address; only bits [ADDR_BITS-1:2] are used.
REQ-007 mem_wdata  input  32  SHALL be the write data, little-endian lanes.
REQ-008 mem_wstrb  input  4  SHALL be the byte strobes; 0 = read word, nonzero = write strobed bytes.
REQ-009 mem_ready  output  1  SHALL be a one-cycle completion pulse.
REQ-010 mem_rdata  output  32  SHALL be the assembled read word.
REQ-011 err  output  1  SHALL be a one-cycle pulse, coincident with mem_ready, when a transaction aborted on timeout.
REQ-012 f_addr  output  ADDR_BITS  SHALL be the FRAM byte address to the downstream SPI master.
REQ-013 f_wdata  output  8  SHALL be the byte to write.
REQ-014 f_write  output  1  SHALL be high for byte writes.
REQ-015 f_valid  output  1  SHALL be the downstream request.
REQ-016 f_ready  input  1  SHALL be the downstream done flag; it stays high until one cycle after f_valid falls.
REQ-017 f_rdata  input  8  SHALL be the byte read, valid while f_ready is high.

Function
REQ-018 States SHALL be IDLE, SELECT, REQ, RELEASE, DONE.
REQ-019 In IDLE with mem_valid high, the bridge SHALL latch addr/wdata/wstrb, set lane=0, clear the abort flag, and go to SELECT.
REQ-020 Transfers SHALL start only when f_ready is low; if f_ready is high in IDLE, the bridge SHALL stay in IDLE.
REQ-021 SELECT on a read SHALL select every lane 0..3.
REQ-022 SELECT on a write SHALL skip lanes whose strobe is 0, advancing one lane per cycle.
REQ-023 SELECT SHALL go to DONE once lane passes 3.
REQ-024 On entering REQ, the bridge SHALL drive f_addr={addr[ADDR_BITS-1:2],lane[1:0]}, f_wdata=wdata[8*lane+:8] and f_write=(wstrb!=0), and set f_valid=1.
REQ-025 f_addr, f_wdata and f_write SHALL be held stable while f_valid is high.
REQ-026 In REQ with f_ready high, the bridge SHALL capture f_rdata into mem_rdata[8*lane+:8] on reads, drop f_valid, and go to RELEASE.
REQ-027 In RELEASE, the bridge SHALL wait for f_ready low, then increment lane and return to SELECT.
REQ-028 A timeout counter SHALL be cleared on entry to REQ and to RELEASE and shall increment each cycle spent in either state.
REQ-029 When the timeout counter reaches TIMEOUT-1, the bridge SHALL set the abort flag, drop f_valid, set unread lanes of mem_rdata to 8'hFF, and go to DONE.
REQ-030 DONE SHALL pulse mem_ready for exactly 1 cycle (plus err if aborted), then go to IDLE.
REQ-031 Total read latency from mem_valid to mem_ready SHALL be 1 + 4*(SELECT+REQ+RELEASE cycles) + 1.
REQ-032 A write with a single strobe SHALL issue exactly one downstream transaction.
REQ-033 mem_rdata SHALL hold its value from mem_ready until the next read captures a lane; writes SHALL leave it unchanged.
REQ-034 A mem_valid drop before mem_ready is illegal; the bridge SHALL ignore it and complete the transaction.
REQ-035 Address bits above ADDR_BITS-1 SHALL be ignored, so addresses wrap modulo 2^ADDR_BITS.

Reset
REQ-036 Under reset, the bridge SHALL go to IDLE with mem_ready=0, err=0, f_valid=0, f_write=0, f_addr=0, f_wdata=0, mem_rdata=0, lane=0 and timeout=0.
REQ-037 Reset asserted mid-transaction SHALL abandon it without issuing mem_ready.
REQ-038 After reset, the bridge SHALL wait for f_ready low before issuing any request (REQ-020).

Structure
REQ-039 The state encoding, TIMEOUT default and ADDR_BITS default SHALL live in shared package fram_pkg, which the SPI master also imports.
REQ-040 No sub-module SHALL be used; the lane counter and timeout counter are inline, and the SPI master is instantiated by the SoC top, not by this block.

Verification
REQ-041 Read, addr 0x0000_0104, FRAM model bytes 0x104..0x107 = 11,22,33,44 -> four reads at f_addr 0x104..0x107 in order; mem_rdata=0x44332211; one mem_ready pulse.
REQ-042 Write, addr 0x0000_0020, wdata 0xAABBCCDD, wstrb 4'b1010 -> exactly two writes: 0x021=CC, then 0x023=AA; mem_rdata unchanged.
REQ-043 Model holding f_ready low forever, TIMEOUT=16 -> abort in REQ after 16 cycles; mem_ready and err pulse together; mem_rdata=0xFFFFFFFF on a first-lane read.
REQ-044 f_ready held high 3 extra cycles after f_valid falls -> no new f_valid until f_ready has been low for 1 cycle.
REQ-045 resetn pulsed low during lane 2 of a read -> f_valid=0 next cycle; no mem_ready; the next read completes correctly.
REQ-046 Address 0x0000_2004 with ADDR_BITS=13 -> f_addr starts at 0x004.
